// File: rtl/riscv_pkg.sv
// RISC-V base definitions used by the Spatz instruction front end.
package riscv_pkg;

    typedef logic [31:0] instr_t;

    localparam logic [6:0] OpcodeVec     = 7'h57;
    localparam logic [6:0] OpcodeLoadFP  = 7'h07;
    localparam logic [6:0] OpcodeStoreFP = 7'h27;
    localparam logic [6:0] OpcodeSystem  = 7'h73;

endpackage

// File: rtl/spatz_pkg.sv
// Shared Spatz types: instruction class and queued offload entry.
package spatz_pkg;
    import riscv_pkg::*;

    localparam int unsigned IdWidth = 5;

    typedef enum logic [1:0] {
        ARITH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        CSR   = 2'd3
    } instr_class_e;

    typedef struct packed {
        instr_t               instr;
        logic [IdWidth-1:0]   id;
        logic [31:0]          rs1;
        instr_class_e         cls;
    } queue_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Small register-based FIFO with exact occupancy count and synchronous flush.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 4,
    parameter type         dtype        = logic,
    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] usage_o,
    input  dtype          data_i,
    input  logic          push_i,
    output dtype          data_o,
    input  logic          pop_i
);

    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    dtype [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    usage_q;
    logic             stored_empty, bypass, do_push, do_pop;

    assign stored_empty = (usage_q == '0);
    assign full_o       = (usage_q == FullCnt);
    assign empty_o      = stored_empty && !(FALL_THROUGH && push_i);
    assign usage_o      = usage_q;
    assign do_push      = push_i && !full_o;
    assign do_pop       = pop_i && !empty_o;
    // An entry pushed into an empty fall-through FIFO and popped at once never lands in storage.
    assign bypass       = FALL_THROUGH && stored_empty && do_push && do_pop;

    // Head presentation; in fall-through mode an empty FIFO forwards the incoming word.
    always_comb begin
        data_o = mem_q[rd_ptr_q];
        if (FALL_THROUGH && stored_empty && push_i) data_o = data_i;
    end

    // Storage, pointers and occupancy; flush has priority over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else if (!bypass) begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop)      usage_q <= usage_q + 1'b1;
            else if (!do_push && do_pop) usage_q <= usage_q - 1'b1;
        end
    end

endmodule

// File: rtl/spatz_instr_queue.sv
// Offload front end: classifies incoming instructions, queues legal ones in
// order for the vector decoder and reports illegal ones via a response register.
module spatz_instr_queue
    import riscv_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  instr_t                     issue_instr_i,
    input  logic [IdWidth-1:0]         issue_id_i,
    input  logic [31:0]                issue_rs1_i,
    input  logic                       flush_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output instr_t                     dec_instr_o,
    output logic [IdWidth-1:0]         dec_id_o,
    output logic [31:0]                dec_rs1_o,
    output logic [1:0]                 dec_class_o,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [IdWidth-1:0]         rsp_id_o,
    output logic                       rsp_error_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    // Queue entries carry the package-wide ID width, so the two must agree.
    if (IdWidth != spatz_pkg::IdWidth) begin : g_bad_id_width
        $error("IdWidth must match spatz_pkg::IdWidth");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("Depth must be a power of two and at least 2");
    end

    spatz_pkg::instr_class_e cls;
    spatz_pkg::queue_entry_t wr_entry, rd_entry;
    logic legal, full, empty, push, pop;
    logic accept_illegal;
    logic rsp_valid_q, rsp_valid_d;
    logic [IdWidth-1:0] rsp_id_q, rsp_id_d;

    // Major-opcode classification of the offered instruction.
    always_comb begin
        legal = 1'b1;
        cls   = spatz_pkg::ARITH;
        unique case (issue_instr_i[6:0])
            OpcodeVec:     cls = spatz_pkg::ARITH;
            OpcodeLoadFP:  cls = spatz_pkg::LOAD;
            OpcodeStoreFP: cls = spatz_pkg::STORE;
            OpcodeSystem:  cls = spatz_pkg::CSR;
            default:       legal = 1'b0;
        endcase
    end

    // Ready depends on where the instruction would go, never on issue_valid_i.
    always_comb begin
        if (legal) issue_ready_o = !full && !flush_i;
        else       issue_ready_o = (!rsp_valid_q || rsp_ready_i) && !flush_i;
    end

    assign push           = issue_valid_i && issue_ready_o && legal;
    assign accept_illegal = issue_valid_i && issue_ready_o && !legal;
    assign pop            = dec_valid_o && dec_ready_i;

    assign wr_entry.instr = issue_instr_i;
    assign wr_entry.id    = issue_id_i;
    assign wr_entry.rs1   = issue_rs1_i;
    assign wr_entry.cls   = cls;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (Depth),
        .dtype        (spatz_pkg::queue_entry_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (count_o),
        .data_i  (wr_entry),
        .push_i  (push),
        .data_o  (rd_entry),
        .pop_i   (pop)
    );

    assign dec_valid_o = !empty;
    assign dec_instr_o = rd_entry.instr;
    assign dec_id_o    = rd_entry.id;
    assign dec_rs1_o   = rd_entry.rs1;
    assign dec_class_o = rd_entry.cls;

    // Response next state: a new illegal accept reloads, a handshake alone clears.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        if (accept_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = issue_id_i;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register; untouched by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_error_o = rsp_valid_q;

endmodule

// File: doc/spatz_instr_queue.md
Name: spatz_instr_queue

Overview:
- Front-end buffer between the scalar core's accelerator-offload port and the Spatz vector decoder.
- Accepts 32-bit instructions over a valid/ready handshake and classifies each by major opcode: vector arithmetic, vector load, vector store, or system/CSR.
- Legal instructions go in order into a small FIFO and are presented to the decoder.
- Instructions with any other opcode are rejected through a one-entry error-response register and never reach the decoder.

Parameters:
- Depth, 4, number of FIFO entries; power of two, at least 2.
- IdWidth, 5, width of the offload transaction ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- issue_valid_i  in  1  offload request valid.
- issue_ready_o  out  1  offload request accepted.
- issue_instr_i  in  32  instruction word (instr_t).
- issue_id_i  in  IdWidth  transaction ID.
- issue_rs1_i  in  32  scalar rs1 operand.
- flush_i  in  1  discard all queued instructions.
- dec_valid_o  out  1  head entry valid.
- dec_ready_i  in  1  decoder pops head.
- dec_instr_o  out  32  head instruction.
- dec_id_o  out  IdWidth  head ID.
- dec_rs1_o  out  32  head rs1 operand.
- dec_class_o  out  2  head class: 0 ARITH, 1 LOAD, 2 STORE, 3 CSR.
- rsp_valid_o  out  1  rejection response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_id_o  out  IdWidth  ID of the rejected instruction.
- rsp_error_o  out  1  illegal-instruction flag; 1 whenever rsp_valid_o is 1.
- count_o  out  $clog2(Depth+1)  current FIFO occupancy.

Behaviour:
- Reset: all state is cleared asynchronously on rst_ni low. All outputs are 0 except issue_ready_o, which is 1 when flush_i is 0.
- Classification is combinational on issue_instr_i[6:0]:
  - OpcodeVec (0x57) -> ARITH
  - OpcodeLoadFP (0x07) -> LOAD
  - OpcodeStoreFP (0x27) -> STORE
  - OpcodeSystem (0x73) -> CSR
  - any other value -> illegal
- issue_ready_o:
  - legal: !full && !flush_i.
  - illegal: (!rsp_valid_o || rsp_ready_i) && !flush_i.
  - It may depend combinationally on issue_instr_i. It must not depend on issue_valid_i.
- Legal accept: {instr, id, rs1, class} is written at the write pointer.
- FIFO is registered, with no fall-through: an entry accepted in cycle N gives dec_valid_o in cycle N+1 at the earliest.
- Pop: when dec_valid_o && dec_ready_i, the read pointer advances. Outputs are driven from the head entry. Output values are don't-care when dec_valid_o is 0, but must hold stable while valid and not popped.
- Push and pop in the same cycle: count unchanged, both pointers advance. When full, a push is refused even if a pop happens that cycle.
- Pointers wrap modulo Depth. Full/empty come from count, and count_o is exact.
- Illegal accept:
  - rsp_valid_o is set the next cycle; rsp_id_o is the issue ID and rsp_error_o is 1.
  - If a response handshake and a new illegal accept happen in the same cycle, the register reloads with the new ID and rsp_valid_o stays 1.
  - rsp_valid_o clears on handshake when there is no new accept.
- Illegal instructions do not change the FIFO or count_o.
- flush_i:
  - Next cycle: count_o is 0, dec_valid_o is 0, and the pointers are reset to 0.
  - A pop in the flush cycle has no additional effect.
  - The response register is unaffected.
  - issue_ready_o is 0 during the flush cycle.
- Ordering: the decoder sees legal instructions strictly in acceptance order. Illegal instructions do not block later legal ones.

Decomposition:
- Shared package spatz_pkg holds:
  - the typedef enum logic [1:0] instr_class_e {ARITH, LOAD, STORE, CSR};
  - the packed struct queue_entry_t {instr_t instr; logic [IdWidth-1:0] id; logic [31:0] rs1; instr_class_e cls}.
- Opcode constants and instr_t are taken from riscv_pkg.
- One sub-module: fifo_v3 from common_cells, used in non-fall-through mode, with flush_i wired to its flush input.
- Classification and the response register stay in the top module.

Test Plan:
- Reset: hold rst_ni low, then release -> dec_valid_o=0, rsp_valid_o=0, count_o=0, issue_ready_o=1.
- Push 0x02008057 with id=3, rs1=0xDEADBEEF, dec_ready_i=0 -> next cycle dec_valid_o=1, dec_class_o=0, dec_id_o=3, dec_rs1_o=0xDEADBEEF, count_o=1.
- With dec_ready_i=0, push loads 0x02056007 (LOAD), 0x02056027 (STORE), 0xC2002073 (CSR) and one more vector instruction -> count_o=4 and issue_ready_o=0 for a legal 5th; one pop -> issue_ready_o=1 next cycle. Classes emerge as 1, 2, 3, 0 in order.
- Illegal 0x00000033 with id=7 -> rsp_valid_o=1, rsp_id_o=7, rsp_error_o=1, count_o unchanged. A second illegal with rsp_ready_i=0 -> issue_ready_o=0; assert rsp_ready_i -> it is accepted in the same cycle and rsp_id_o updates.
- Three entries queued, assert flush_i for one cycle -> next cycle count_o=0 and dec_valid_o=0; a pending response stays valid.
- Ten back-to-back push/pop pairs with ids 0..9, dec_ready_i=1 -> ids emerge 0..9 in order across pointer wrap, count_o never exceeds 1.
